squeeze_output_ctrl: RTL and testbench

- Squeeze-side counterpart of the absorb padding path in the SHAKE core.
- Reads rate words from the Keccak state and streams them out as w-bit words with a valid-byte count.
- Truncates the final word to the requested output length and requests extra permutations when a rate block is exhausted.
- Sits between the state register file / permutation controller and the core's output stream.

---
 rtl/squeeze_output_ctrl_if.sv | 28 ++
 rtl/squeeze_output_ctrl.sv | 116 +++++++++++
 tb/tb_squeeze_output_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/squeeze_output_ctrl_if.sv
// Output word stream of the squeeze path: data word, valid-byte count,
// last-word flag and a valid/ready handshake.
interface squeeze_output_ctrl_if #(
    parameter int W  = 64,
    parameter int BW = 4
);
    logic [W-1:0]  dout;
    logic [BW-1:0] dout_bytes;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;

    modport master (
        output dout,
        output dout_bytes,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_bytes,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/squeeze_output_ctrl.sv
// Squeeze output controller: walks the rate words of the Keccak state,
// streams them out truncated to the requested length (valid bytes in the
// high end of the word) and asks for another permutation per exhausted block.
package keccak_pkg;
    localparam int w            = 64;
    localparam int w_byte_size  = w / 8;
    localparam int w_byte_width = $clog2(w_byte_size);
endpackage

module squeeze_output_ctrl
    import keccak_pkg::*;
#(
    parameter int RATE_WORDS = 21,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [LEN_WIDTH-1:0]          i_out_len,
    output logic [$clog2(RATE_WORDS)-1:0] o_rd_idx,
    input  logic [w-1:0]                  i_rd_word,
    output logic                          o_perm_start,
    input  logic                          i_perm_done,
    output logic                          o_busy,
    output logic                          o_done,
    squeeze_output_ctrl_if.master         o_stream
);
    localparam int IDX_W   = $clog2(RATE_WORDS);
    localparam int BYTES_W = w_byte_width + 1;
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(RATE_WORDS - 1);
    localparam logic [LEN_WIDTH-1:0] WORD_BYTES = LEN_WIDTH'(w_byte_size);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_PERM_REQ,
        S_PERM_WAIT,
        S_FINISH
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0] r_remaining, w_remaining_nxt;
    logic [IDX_W-1:0]     r_rd_idx, w_rd_idx_nxt;

    logic                 w_emit;
    logic                 w_last;
    logic [BYTES_W-1:0]   w_bytes;
    logic [w-1:0]         w_mask;

    assign w_emit  = (r_state == S_EMIT);
    assign w_last  = w_emit && (r_remaining <= WORD_BYTES);
    // Short tail word carries the leftover count, otherwise a full word;
    // zero outside EMIT so the stream is quiet when not presenting data.
    assign w_bytes = !w_emit                  ? '0 :
                     (r_remaining < WORD_BYTES) ? r_remaining[BYTES_W-1:0] :
                                                  BYTES_W'(w_byte_size);
    // Keep the top w_bytes bytes; a shift of the full width yields all-ones.
    assign w_mask  = ~({w{1'b1}} >> {w_bytes, 3'b000});

    assign o_stream.dout       = i_rd_word & w_mask;
    assign o_stream.dout_bytes = w_bytes;
    assign o_stream.dout_valid = w_emit;
    assign o_stream.dout_last  = w_last;
    assign o_rd_idx            = r_rd_idx;
    assign o_perm_start        = (r_state == S_PERM_REQ);
    assign o_done              = (r_state == S_FINISH);
    assign o_busy              = w_emit || (r_state == S_PERM_REQ) ||
                                 (r_state == S_PERM_WAIT);

    // State, remaining-byte counter and read index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_rd_idx    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
        end
    end

    // Next-state, counter and index update.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_rd_idx_nxt    = r_rd_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_remaining_nxt = i_out_len;
                    w_rd_idx_nxt    = '0;
                    w_state_nxt     = (i_out_len != '0) ? S_EMIT : S_FINISH;
                end
            end
            S_EMIT: begin
                if (o_stream.dout_ready) begin
                    // w_bytes never exceeds remaining, so no underflow.
                    w_remaining_nxt = r_remaining - LEN_WIDTH'(w_bytes);
                    if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else if (r_rd_idx == LAST_IDX) begin
                        w_rd_idx_nxt = '0;
                        w_state_nxt  = S_PERM_REQ;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + 1'b1;
                    end
                end
            end
            S_PERM_REQ:  w_state_nxt = S_PERM_WAIT;
            S_PERM_WAIT: if (i_perm_done) w_state_nxt = S_EMIT;
            S_FINISH:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_squeeze_output_ctrl.sv
// Randomized bench for squeeze_output_ctrl against a byte-level model of
// the expected output stream built from a table of state blocks.
module tb_squeeze_output_ctrl;
    import keccak_pkg::*;

    localparam int RW = 21;
    localparam int LW = 32;
    localparam int IW = $clog2(RW);
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] out_len;
    logic [IW-1:0] rd_idx;
    logic [w-1:0]  rd_word;
    logic          perm_start;
    logic          perm_done;
    logic          busy;
    logic          done;

    squeeze_output_ctrl_if #(.W(w), .BW(w_byte_width + 1)) sif ();

    squeeze_output_ctrl #(.RATE_WORDS(RW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_out_len   (out_len),
        .o_rd_idx    (rd_idx),
        .i_rd_word   (rd_word),
        .o_perm_start(perm_start),
        .i_perm_done (perm_done),
        .o_busy      (busy),
        .o_done      (done),
        .o_stream    (sif)
    );

    always #5 clk = ~clk;

    logic [63:0] blk_mem [0:NB-1][0:RW-1];
    int          cur_blk;
    int          n_chk;
    int          n_pass;

    always_comb rd_word = blk_mem[cur_blk][rd_idx];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Expected k-th output word: top n bytes of the k-th rate word overall.
    function automatic logic [63:0] exp_word(int len, int k);
        logic [63:0] data, res;
        int n;
        data = blk_mem[k / RW][k % RW];
        n    = (len - 8 * k < 8) ? len - 8 * k : 8;
        res  = '0;
        for (int b = 0; b < n; b++) res[63 - 8 * b -: 8] = data[63 - 8 * b -: 8];
        return res;
    endfunction

    task automatic fill_blocks(input bit directed);
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < RW; i++) blk_mem[b][i] = {$urandom, $urandom};
        if (directed) blk_mem[0][0] = 64'h0123456789ABCDEF;
        cur_blk = 0;
    endtask

    // mode 0: ready always high, 1: random, 2: pattern 1,0,0 repeating.
    task automatic run_req(input int len, input int mode, input bit directed,
                           output logic [63:0] first_word);
        logic [63:0] od[$];
        int          ob[$];
        bit          ol[$];
        int          nwords, lat, first_v, done_cyc, nperm, ptimer, exp_perm, n;
        bit          fin, prev_stall, rdy;
        logic [63:0] pd;
        logic [3:0]  pb;
        logic        pl;
        logic [IW-1:0] pi;
        fill_blocks(directed);
        lat = $urandom_range(1, 4);
        nwords = (len + 7) / 8;
        first_v = -1; done_cyc = -1; nperm = 0; ptimer = 0;
        fin = 0; prev_stall = 0; pd = '0; pb = '0; pl = 0; pi = '0;
        first_word = '0;
        @(negedge clk);
        start = 1'b1;
        out_len = LW'(len);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            perm_done = 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = ((cyc - 1) % 3 == 0);
            endcase
            sif.dout_ready = rdy;
            if (prev_stall) begin
                chk("stall_dout", sif.dout, pd);
                chk("stall_bytes", 64'(sif.dout_bytes), 64'(pb));
                chk("stall_last", 64'(sif.dout_last), 64'(pl));
                chk("stall_idx", 64'(rd_idx), 64'(pi));
            end
            chk("busy", 64'(busy), 64'(len > 0 && !done));
            if (sif.dout_valid && first_v < 0) first_v = cyc;
            if (sif.dout_valid && rdy) begin
                od.push_back(sif.dout);
                ob.push_back(int'(sif.dout_bytes));
                ol.push_back(sif.dout_last);
            end
            prev_stall = sif.dout_valid && !rdy;
            pd = sif.dout; pb = sif.dout_bytes; pl = sif.dout_last; pi = rd_idx;
            if (perm_start) begin
                nperm++;
                ptimer = lat;
                if ($urandom_range(0, 1) == 1) perm_done = 1'b1;
            end else if (ptimer > 0) begin
                ptimer--;
                if (ptimer == 0) begin
                    perm_done = 1'b1;
                    if (cur_blk < NB - 1) cur_blk++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1;
                break;
            end
        end
        if (!fin) chk("timeout", 64'd0, 64'd1);
        perm_done = 1'b0;
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        chk("idle_valid", 64'(sif.dout_valid), 64'd0);
        exp_perm = (nwords > 0) ? (nwords - 1) / RW : 0;
        chk("nwords", 64'(od.size()), 64'(nwords));
        chk("nperm", 64'(nperm), 64'(exp_perm));
        chk("first_valid", 64'(first_v), 64'(len > 0 ? 1 : -1));
        if (mode == 0)
            chk("done_cyc", 64'(done_cyc), 64'(nwords + 1 + exp_perm * (1 + lat)));
        n = (od.size() < nwords) ? od.size() : nwords;
        for (int k = 0; k < n; k++) begin
            chk("word", od[k], exp_word(len, k));
            chk("bytes", 64'(ob[k]), 64'((len - 8 * k < 8) ? len - 8 * k : 8));
            chk("last", 64'(ol[k]), 64'(k == nwords - 1));
        end
        if (od.size() > 0) first_word = od[0];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(sif.dout_valid), 64'd0);
        chk({tag, "_perm"}, 64'(perm_start), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_last"}, 64'(sif.dout_last), 64'd0);
        chk({tag, "_bytes"}, 64'(sif.dout_bytes), 64'd0);
        chk({tag, "_idx"}, 64'(rd_idx), 64'd0);
        chk({tag, "_dout"}, sif.dout, 64'd0);
    endtask

    initial begin
        logic [63:0] fw;
        bit          seen;
        n_chk = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; out_len = '0; perm_done = 1'b0;
        sif.dout_ready = 1'b0;
        fill_blocks(0);
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        run_req(8, 0, 1, fw);
        chk("full_word", fw, 64'h0123456789ABCDEF);
        run_req(3, 0, 1, fw);
        chk("trunc_word", fw, 64'h0123450000000000);
        run_req(200, 0, 0, fw);
        run_req(168, 0, 0, fw);
        run_req(176, 1, 0, fw);
        run_req(20, 2, 0, fw);
        run_req(0, 0, 0, fw);

        // Reset while waiting for a permutation.
        fill_blocks(0);
        sif.dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        out_len = 200;
        seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (perm_start) begin
                seen = 1;
                break;
            end
        end
        chk("rst_perm_seen", 64'(seen), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_quiet", 64'(perm_start | sif.dout_valid | busy), 64'd0);
        end
        run_req(8, 0, 1, fw);
        chk("after_rst_word", fw, 64'h0123456789ABCDEF);

        for (int t = 0; t < 8; t++)
            run_req($urandom_range(1, 504), $urandom_range(0, 2), 0, fw);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
